// File: rtl/move_controller.sv
// Othello move engine: owns the 8x8 board and answers the new_move/ack
// handshake. It validates a move by walking each of the eight rays from the
// target, flips captured discs ray by ray and then places the disc. It also
// keeps registered disc counts and a game-over flag.
module move_controller #(
  parameter int MAX_SCAN = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       init_start,
  output logic       init_end,
  input  logic       new_move,
  input  logic       player,
  input  logic [2:0] move_x,
  input  logic [2:0] move_y,
  output logic       ack,
  output logic       reject,
  input  logic [2:0] rd_x,
  input  logic [2:0] rd_y,
  output logic [1:0] rd_cell,
  output logic [6:0] black_count,
  output logic [6:0] white_count,
  output logic       game_end
);

  localparam int SW = $clog2(MAX_SCAN);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_INIT      = 4'd1;
  localparam logic [3:0] S_INIT_DONE = 4'd2;
  localparam logic [3:0] S_CHECK     = 4'd3;
  localparam logic [3:0] S_DIR_START = 4'd4;
  localparam logic [3:0] S_WALK      = 4'd5;
  localparam logic [3:0] S_FLIP      = 4'd6;
  localparam logic [3:0] S_NEXT_DIR  = 4'd7;
  localparam logic [3:0] S_FINISH    = 4'd8;
  localparam logic [3:0] S_HOLD      = 4'd9;

  logic [63:0][1:0] board_q, board_d;
  logic [3:0]       state_q, state_d;
  logic             armed_q, armed_d;
  logic [2:0]       tx_q, tx_d, ty_q, ty_d;
  logic             tpl_q, tpl_d;
  logic [2:0]       dir_q, dir_d;
  // Pointer coordinates carry one extra bit: stepping off either edge
  // (to -1 or to 8) sets bit 3.
  logic [3:0]       px_q, px_d, py_q, py_d;
  logic [SW-1:0]    steps_q, steps_d;
  logic             any_flip_q, any_flip_d;
  logic [2:0]       hx_q, hx_d, hy_q, hy_d;
  logic             ack_q, ack_d, reject_q, reject_d, init_end_q, init_end_d;
  logic [6:0]       black_q, black_d, white_q, white_d;
  logic             game_end_q, game_end_d;

  // Ray direction to {dx, dy} in 4-bit two's complement; north is y-1.
  function automatic logic [7:0] delta(input logic [2:0] d);
    case (d)
      3'd0:    delta = {4'h1, 4'h0};  // E
      3'd1:    delta = {4'h1, 4'hF};  // NE
      3'd2:    delta = {4'h0, 4'hF};  // N
      3'd3:    delta = {4'hF, 4'hF};  // NW
      3'd4:    delta = {4'hF, 4'h0};  // W
      3'd5:    delta = {4'hF, 4'h1};  // SW
      3'd6:    delta = {4'h0, 4'h1};  // S
      default: delta = {4'h1, 4'h1};  // SE
    endcase
  endfunction

  logic [3:0] dx, dy, bx, by;
  logic [1:0] own, opp, cur;
  logic       off;

  // Move sequencing, board writes and result pulses.
  always_comb begin
    board_d    = board_q;
    state_d    = state_q;
    armed_d    = armed_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    tpl_d      = tpl_q;
    dir_d      = dir_q;
    px_d       = px_q;
    py_d       = py_q;
    steps_d    = steps_q;
    any_flip_d = any_flip_q;
    hx_d       = hx_q;
    hy_d       = hy_q;
    ack_d      = 1'b0;
    reject_d   = 1'b0;
    init_end_d = 1'b0;
    {dx, dy}   = delta(dir_q);
    bx         = px_q - dx;
    by         = py_q - dy;
    own        = tpl_q ? 2'b10 : 2'b01;
    opp        = tpl_q ? 2'b01 : 2'b10;
    off        = px_q[3] | py_q[3];
    cur        = board_q[{py_q[2:0], px_q[2:0]}];
    case (state_q)
      S_IDLE: begin
        if (init_start) begin
          state_d = S_INIT;
        end else if (new_move && armed_q) begin
          tx_d    = move_x;
          ty_d    = move_y;
          tpl_d   = player;
          state_d = S_CHECK;
        end
      end
      S_INIT: begin
        board_d     = '0;
        board_d[27] = 2'b10;  // (3,3)
        board_d[36] = 2'b10;  // (4,4)
        board_d[35] = 2'b01;  // (3,4)
        board_d[28] = 2'b01;  // (4,3)
        armed_d     = 1'b1;
        init_end_d  = 1'b1;
        state_d     = S_INIT_DONE;
      end
      S_INIT_DONE: begin
        if (!init_start) state_d = S_IDLE;
      end
      S_CHECK: begin
        any_flip_d = 1'b0;
        dir_d      = 3'd0;
        state_d    = (board_q[{ty_q, tx_q}] != 2'b00) ? S_FINISH : S_DIR_START;
      end
      S_DIR_START: begin
        px_d    = {1'b0, tx_q} + dx;
        py_d    = {1'b0, ty_q} + dy;
        steps_d = '0;
        state_d = S_WALK;
      end
      S_WALK: begin
        if (off || cur == 2'b00) begin
          state_d = S_NEXT_DIR;
        end else if (cur == opp) begin
          steps_d = steps_q + 1'b1;
          px_d    = px_q + dx;
          py_d    = py_q + dy;
        end else if (steps_q == '0) begin
          state_d = S_NEXT_DIR;
        end else begin
          px_d    = bx;
          py_d    = by;
          state_d = S_FLIP;
        end
      end
      S_FLIP: begin
        board_d[{py_q[2:0], px_q[2:0]}] = own;
        any_flip_d = 1'b1;
        px_d       = bx;
        py_d       = by;
        if (bx == {1'b0, tx_q} && by == {1'b0, ty_q}) state_d = S_NEXT_DIR;
      end
      S_NEXT_DIR: begin
        if (dir_q == 3'd7) begin
          state_d = S_FINISH;
        end else begin
          dir_d   = dir_q + 3'd1;
          state_d = S_DIR_START;
        end
      end
      S_FINISH: begin
        if (any_flip_q) begin
          board_d[{ty_q, tx_q}] = own;
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          reject_d = 1'b1;
          hx_d     = tx_q;
          hy_d     = ty_q;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!new_move || move_x != hx_q || move_y != hy_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Disc counts and game-over flag derived from the current board, so both
  // settle in the same cycle one clock after a board change.
  always_comb begin
    black_d = '0;
    white_d = '0;
    for (int i = 0; i < 64; i++) begin
      if (board_q[i] == 2'b01) black_d = black_d + 7'd1;
      if (board_q[i] == 2'b10) white_d = white_d + 7'd1;
    end
    game_end_d = (state_q != S_INIT) && armed_q &&
                 (({1'b0, black_d} + {1'b0, white_d} == 8'd64) ||
                  black_d == 7'd0 || white_d == 7'd0);
  end

  // State registers with synchronous reset clearing the whole board.
  always_ff @(posedge clock) begin
    if (reset) begin
      board_q    <= '0;
      state_q    <= S_IDLE;
      armed_q    <= 1'b0;
      tx_q       <= '0;
      ty_q       <= '0;
      tpl_q      <= 1'b0;
      dir_q      <= '0;
      px_q       <= '0;
      py_q       <= '0;
      steps_q    <= '0;
      any_flip_q <= 1'b0;
      hx_q       <= '0;
      hy_q       <= '0;
      ack_q      <= 1'b0;
      reject_q   <= 1'b0;
      init_end_q <= 1'b0;
      black_q    <= '0;
      white_q    <= '0;
      game_end_q <= 1'b0;
    end else begin
      board_q    <= board_d;
      state_q    <= state_d;
      armed_q    <= armed_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      tpl_q      <= tpl_d;
      dir_q      <= dir_d;
      px_q       <= px_d;
      py_q       <= py_d;
      steps_q    <= steps_d;
      any_flip_q <= any_flip_d;
      hx_q       <= hx_d;
      hy_q       <= hy_d;
      ack_q      <= ack_d;
      reject_q   <= reject_d;
      init_end_q <= init_end_d;
      black_q    <= black_d;
      white_q    <= white_d;
      game_end_q <= game_end_d;
    end
  end

  assign rd_cell     = board_q[{rd_y, rd_x}];
  assign ack         = ack_q;
  assign reject      = reject_q;
  assign init_end    = init_end_q;
  assign black_count = black_q;
  assign white_count = white_q;
  assign game_end    = game_end_q;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: directed handshake scenarios followed by random
// moves checked against an array-based Othello reference model.
module tb_move_controller;
  logic       clock = 1'b0;
  logic       reset, init_start, new_move, player;
  logic [2:0] move_x, move_y, rd_x, rd_y;
  logic       init_end, ack, reject, game_end;
  logic [1:0] rd_cell;
  logic [6:0] black_count, white_count;

  move_controller dut (
    .clock(clock), .reset(reset), .init_start(init_start), .init_end(init_end),
    .new_move(new_move), .player(player), .move_x(move_x), .move_y(move_y),
    .ack(ack), .reject(reject), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell),
    .black_count(black_count), .white_count(white_count), .game_end(game_end)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  int bd[64];
  bit armed_m = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cnt(input int c);
    int n = 0;
    for (int i = 0; i < 64; i++) if (bd[i] == c) n++;
    return n;
  endfunction

  // Number of opponent discs captured along one ray, 0 if none.
  function automatic int ray(input int p, input int x, input int y, input int dx, input int dy);
    int own = p + 1, opp = 2 - p, n = 0, cx = x + dx, cy = y + dy;
    while (cx >= 0 && cx < 8 && cy >= 0 && cy < 8 && bd[cy*8+cx] == opp) begin
      n++; cx += dx; cy += dy;
    end
    if (cx >= 0 && cx < 8 && cy >= 0 && cy < 8 && bd[cy*8+cx] == own) return n;
    return 0;
  endfunction

  function automatic bit legal(input int p, input int x, input int y);
    if (bd[y*8+x] != 0) return 1'b0;
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++)
        if ((dx != 0 || dy != 0) && ray(p, x, y, dx, dy) > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_apply(input int p, input int x, input int y);
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++)
        if (dx != 0 || dy != 0) begin
          int n = ray(p, x, y, dx, dy);
          for (int k = 1; k <= n; k++) bd[(y+k*dy)*8 + x+k*dx] = p + 1;
        end
    bd[y*8+x] = p + 1;
  endtask

  task automatic read_cell(input int x, input int y, output int v);
    rd_x = 3'(x); rd_y = 3'(y);
    #1 v = int'(rd_cell);
  endtask

  task automatic cmp_state(input string tag);
    int bad = 0, v;
    int b = cnt(1), w = cnt(2);
    for (int i = 0; i < 64; i++) begin
      read_cell(i % 8, i / 8, v);
      if (v != bd[i]) bad++;
    end
    chk({tag, "_board_bad_cells"}, bad, 0);
    chk({tag, "_black"}, int'(black_count), b);
    chk({tag, "_white"}, int'(white_count), w);
    chk({tag, "_game_end"}, int'(game_end), int'(armed_m && (b + w == 64 || b == 0 || w == 0)));
  endtask

  task automatic wait_resp(output bit ga, output bit gr, output int lat);
    ga = 0; gr = 0; lat = 0;
    while (lat < 200 && !ga && !gr) begin
      @(negedge clock);
      lat++;
      if (ack && reject) chk("ack_reject_same_cycle", 1, 0);
      ga = ack; gr = reject;
    end
    if (!ga && !gr) chk("response_timeout", 0, 1);
  endtask

  task automatic do_move(input int p, input int x, input int y, input bit keep,
                         output bit ga, output bit gr, output int lat);
    @(negedge clock);
    player = p[0]; move_x = 3'(x); move_y = 3'(y); new_move = 1'b1;
    wait_resp(ga, gr, lat);
    if (!keep) new_move = 1'b0;
    @(negedge clock);
    chk("pulse_one_cycle", int'(ack | reject), 0);
  endtask

  task automatic do_init();
    int lat = 0, v;
    @(negedge clock);
    init_start = 1'b1;
    while (lat < 10 && !init_end) begin
      @(negedge clock);
      lat++;
    end
    chk("init_latency", lat, 2);
    @(negedge clock);
    chk("init_end_pulse", int'(init_end), 0);
    init_start = 1'b0;
    repeat (2) @(negedge clock);
    foreach (bd[i]) bd[i] = 0;
    bd[3*8+3] = 2; bd[4*8+4] = 2; bd[4*8+3] = 1; bd[3*8+4] = 1;
    armed_m = 1'b1;
    read_cell(3, 3, v); chk("init_cell33", v, 2);
    read_cell(4, 3, v); chk("init_cell43", v, 1);
    cmp_state("init");
  endtask

  initial begin
    bit ga, gr;
    int lat, n, v, p, x, y;
    int cand[$];
    reset = 1'b1; init_start = 0; new_move = 0; player = 0;
    move_x = 0; move_y = 0; rd_x = 0; rd_y = 0;
    foreach (bd[i]) bd[i] = 0;
    repeat (3) @(negedge clock);
    chk("rst_ack", int'(ack), 0);
    chk("rst_reject", int'(reject), 0);
    chk("rst_init_end", int'(init_end), 0);
    cmp_state("rst");
    reset = 1'b0;

    do_init();

    // Illegal move, held: only one reject until the cursor moves.
    do_move(0, 0, 3, 1'b1, ga, gr, lat);
    chk("illegal_reject", int'(gr), 1);
    n = 0;
    repeat (10) begin
      @(negedge clock);
      if (reject || ack) n++;
    end
    chk("hold_no_repeat", n, 0);
    move_x = 3'd2;
    wait_resp(ga, gr, lat);
    new_move = 1'b0;
    chk("moved_cursor_ack", int'(ga), 1);
    chk("ack_latency_bound", int'(lat <= 117), 1);
    @(negedge clock);
    model_apply(0, 2, 3);
    read_cell(3, 3, v); chk("flip_cell33", v, 1);
    cmp_state("first_move");
    chk("first_move_counts", int'(black_count) * 100 + int'(white_count), 401);

    do_move(0, 0, 0, 1'b0, ga, gr, lat);
    chk("corner_reject", int'(gr), 1);
    cmp_state("corner_unchanged");

    // Occupied target: rejected on the third edge counting acceptance.
    do_move(1, 3, 3, 1'b0, ga, gr, lat);
    chk("occupied_reject", int'(gr), 1);
    chk("occupied_latency", lat, 3);
    cmp_state("occupied_unchanged");

    do_move(1, 2, 2, 1'b0, ga, gr, lat);
    chk("white_22_ack", int'(ga), 1);
    model_apply(1, 2, 2);
    do_move(0, 3, 2, 1'b0, ga, gr, lat);
    chk("black_32_ack", int'(ga), 1);
    model_apply(0, 3, 2);
    cmp_state("multi_ray");
    chk("multi_ray_counts", int'(black_count) * 100 + int'(white_count), 502);
    read_cell(2, 2, v); chk("multi_ray_cell22", v, 2);

    // Reset while the engine is walking a ray.
    do_init();
    @(negedge clock);
    player = 0; move_x = 3'd2; move_y = 3'd3; new_move = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    foreach (bd[i]) bd[i] = 0;
    armed_m = 1'b0;
    chk("midwalk_rst_ack", int'(ack), 0);
    cmp_state("midwalk_rst");
    n = 0;
    repeat (20) begin
      @(negedge clock);
      if (ack || reject) n++;
    end
    chk("unarmed_ignored", n, 0);
    new_move = 1'b0;

    // Random play against the reference model.
    do_init();
    for (int t = 0; t < 120; t++) begin
      p = int'($urandom_range(1));
      cand.delete();
      for (int i = 0; i < 64; i++) if (legal(p, i % 8, i / 8)) cand.push_back(i);
      if (cand.size() == 0 && !legal(1 - p, 0, 0)) begin
        bit none = 1'b1;
        for (int i = 0; i < 64; i++) if (legal(1 - p, i % 8, i / 8)) none = 1'b0;
        if (none) begin
          do_init();
          continue;
        end
      end
      if (cand.size() != 0 && $urandom_range(1) == 1) begin
        n = cand[$urandom_range(cand.size() - 1)];
        x = n % 8; y = n / 8;
      end else begin
        x = int'($urandom_range(7)); y = int'($urandom_range(7));
      end
      v = int'(legal(p, x, y));
      do_move(p, x, y, 1'b0, ga, gr, lat);
      chk("rnd_outcome", int'(ga), v);
      chk("rnd_latency_bound", int'(lat <= 117), 1);
      if (v != 0) model_apply(p, x, y);
      cmp_state("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
